// File: rtl/reflex_game_ctrl.sv
// reflex_game_ctrl: game sequencer for a click-the-ball reaction game.
// Spawns a ball, times the player's reaction in milliseconds, scores hits
// inside HIT_RADIUS and counts timeouts as misses until MAX_MISSES ends the game.
// Optional feature: define REFLEX_BEST_TIME_EN to track the fastest hit per
// game on best_ms; without it best_ms is tied to 0.
// new_ball is registered, so ball_gen sees it one cycle after SPAWN.
module reflex_game_ctrl #(
  parameter int MS_DIV     = 100000,
  parameter int TIMEOUT_MS = 1000,
  parameter int MAX_MISSES = 3,
  parameter int HIT_RADIUS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MOUSE_LEFT,
  input  logic [9:0]  MOUSE_X_POS,
  input  logic [9:0]  MOUSE_Y_POS,
  input  logic [9:0]  ballX,
  input  logic [9:0]  ballY,
  output logic        new_ball,
  output logic        enable_ball_gate,
  output logic [9:0]  score,
  output logic [2:0]  misses,
  output logic [13:0] last_ms,
  output logic [13:0] best_ms,
  output logic        game_over
);

  typedef enum logic [2:0] {
    IDLE, SPAWN, ARM, ACTIVE, CHECK, HIT, MISS, GAME_OVER
  } state_t;

  localparam int              PRE_W      = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(MS_DIV - 1);
  localparam logic [13:0]     MS_MAX     = 14'd9999;
  localparam logic [13:0]     TIMEOUT    = 14'(TIMEOUT_MS);
  localparam logic [9:0]      SCORE_MAX  = 10'd999;
  localparam logic [2:0]      MISS_LIMIT = 3'(MAX_MISSES);
  localparam logic [20:0]     RADIUS_SQ  = 21'(HIT_RADIUS * HIT_RADIUS);

  state_t           state, next_state;
  logic [PRE_W-1:0] prescaler;
  logic [13:0]      ms_cnt;
  logic             mouse_left_q;
  logic [9:0]       mouse_x_q, mouse_y_q;
  logic             click, timed_out, in_reach, game_start, new_ball_d;
  logic signed [10:0] dx, dy;
  logic signed [20:0] dx_w, dy_w;
  logic [20:0]      dist_sq;

  // Rising edge of the button against its registered copy.
  assign click      = MOUSE_LEFT & ~mouse_left_q;
  assign timed_out  = (ms_cnt >= TIMEOUT);
  assign game_start = ((state == IDLE) || (state == GAME_OVER)) && start;

  // Squared distance between captured click and ball centre. Sign-extending
  // to 21 bits keeps the squares exact (max 639^2 + 479^2 < 2^20).
  assign dx      = $signed({1'b0, mouse_x_q}) - $signed({1'b0, ballX});
  assign dy      = $signed({1'b0, mouse_y_q}) - $signed({1'b0, ballY});
  assign dx_w    = 21'(dx);
  assign dy_w    = 21'(dy);
  assign dist_sq = $unsigned(dx_w * dx_w + dy_w * dy_w);
  assign in_reach = (dist_sq <= RADIUS_SQ);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_state unassigned
    // (which would infer a latch).
    next_state = state;
    unique case (state)
      IDLE, GAME_OVER: if (start) next_state = SPAWN;
      SPAWN:           next_state = ARM;
      ARM:             next_state = ACTIVE;
      ACTIVE: begin
        // A click in the timeout cycle still gets its CHECK.
        if (click)          next_state = CHECK;
        else if (timed_out) next_state = MISS;
      end
      CHECK: begin
        if (in_reach)       next_state = HIT;
        else if (timed_out) next_state = MISS;
        else                next_state = ACTIVE;
      end
      HIT:  next_state = SPAWN;
      MISS: next_state = ((misses + 3'd1) == MISS_LIMIT) ? GAME_OVER : SPAWN;
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    new_ball_d       = (state == SPAWN);
    enable_ball_gate = (state == ACTIVE) || (state == CHECK);
    game_over        = (state == GAME_OVER);
  end

  // Registered new-ball request: one pulse per SPAWN visit.
  always_ff @(posedge clk) begin
    if (rst) new_ball <= 1'b0;
    else     new_ball <= new_ball_d;
  end

  // Millisecond prescaler and saturating reaction-time counter.
  always_ff @(posedge clk) begin
    if (rst || state == ARM) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (state == ACTIVE || state == CHECK) begin
      if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        if (ms_cnt != MS_MAX) ms_cnt <= ms_cnt + 14'd1;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // Button history and click-position capture (only while the ball is live).
  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_left_q <= 1'b0;
      mouse_x_q    <= '0;
      mouse_y_q    <= '0;
    end else begin
      mouse_left_q <= MOUSE_LEFT;
      if (state == ACTIVE && click) begin
        mouse_x_q <= MOUSE_X_POS;
        mouse_y_q <= MOUSE_Y_POS;
      end
    end
  end

  // Score, miss count and last reaction time.
  always_ff @(posedge clk) begin
    if (rst || game_start) begin
      score   <= '0;
      misses  <= '0;
      last_ms <= '0;
    end else if (state == HIT) begin
      last_ms <= ms_cnt;
      if (score != SCORE_MAX) score <= score + 10'd1;
    end else if (state == MISS) begin
      misses <= misses + 3'd1;
    end
  end

`ifdef REFLEX_BEST_TIME_EN
  // Fastest hit this game; compares against the value being latched into last_ms.
  always_ff @(posedge clk) begin
    if (rst || game_start)                best_ms <= MS_MAX;
    else if (state == HIT && ms_cnt < best_ms) best_ms <= ms_cnt;
  end
`else
  assign best_ms = '0;
`endif

endmodule

// File: tb/tb_reflex_game_ctrl.sv
// Self-checking bench for reflex_game_ctrl (MS_DIV=4, TIMEOUT_MS=10,
// MAX_MISSES=3, HIT_RADIUS=16). The bench plays ball_gen and the mouse.
// Ball outcomes are predicted when the click (or lack of one) is decided and
// queued; they are popped when the DUT spawns the next ball or ends the game.
// Cycle numbers count edges from the first ACTIVE edge (E0) of each ball:
// ms = n after edge 4n, so a click pressed after edge k is judged at k+2.
module tb_reflex_game_ctrl;

`ifdef REFLEX_BEST_TIME_EN
  localparam int BEST_RST = 9999;
`else
  localparam int BEST_RST = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, mouse_left;
  logic [9:0]  mouse_x, mouse_y, ball_x, ball_y;
  logic        new_ball, enable_ball_gate, game_over;
  logic [9:0]  score;
  logic [2:0]  misses;
  logic [13:0] last_ms, best_ms;

  reflex_game_ctrl #(
    .MS_DIV(4), .TIMEOUT_MS(10), .MAX_MISSES(3), .HIT_RADIUS(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .MOUSE_LEFT(mouse_left),
    .MOUSE_X_POS(mouse_x), .MOUSE_Y_POS(mouse_y), .ballX(ball_x), .ballY(ball_y),
    .new_ball(new_ball), .enable_ball_gate(enable_ball_gate), .score(score),
    .misses(misses), .last_ms(last_ms), .best_ms(best_ms), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit over;
    int cycles;
    int score;
    int misses;
    int last_ms;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   e0 = 0;
  int   model_best = BEST_RST;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_edge(input int k);
    while (cyc - e0 < k) step();
  endtask

  task automatic note_hit(input int lm);
`ifdef REFLEX_BEST_TIME_EN
    if (lm < model_best) model_best = lm;
`endif
  endtask

  task automatic push_expect(input bit over, input int cycles, input int sc,
                             input int mi, input int lm);
    exp_t e;
    e.over = over; e.cycles = cycles; e.score = sc; e.misses = mi; e.last_ms = lm;
    sb.push_back(e);
  endtask

  task automatic wait_active();
    int n = 0;
    while (enable_ball_gate !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (enable_ball_gate !== 1'b1) begin
      errors++;
      $display("FAIL wait_active: enable_ball_gate=%b after %0d cycles, required 1",
               enable_ball_gate, n);
    end
    e0 = cyc;
  endtask

  task automatic click(input int x, input int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
    mouse_left = 1'b1;
    step();
    mouse_left = 1'b0;
  endtask

  task automatic wait_outcome(input string name);
    exp_t e;
    int n = 0;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, required a queued outcome", name);
    end else begin
      e = sb.pop_front();
      while (new_ball !== 1'b1 && game_over !== 1'b1 && n < 200) begin
        step();
        n++;
      end
      if ((cyc - e0) != e.cycles || game_over !== e.over) begin
        errors++;
        $display("FAIL %s timing: cycle %0d game_over=%b, required cycle %0d game_over=%b",
                 name, cyc - e0, game_over, e.cycles, e.over);
      end
      checks++;
      if ({score, misses, last_ms} !== {10'(e.score), 3'(e.misses), 14'(e.last_ms)}) begin
        errors++;
        $display("FAIL %s counters: score=%0d misses=%0d last_ms=%0d, required %0d %0d %0d",
                 name, score, misses, last_ms, e.score, e.misses, e.last_ms);
      end
      checks++;
      if (best_ms !== 14'(model_best)) begin
        errors++;
        $display("FAIL %s best_ms: got %0d, required %0d", name, best_ms, model_best);
      end
      if (!e.over) begin
        step();
        checks++;
        if (new_ball !== 1'b0 || enable_ball_gate !== 1'b1) begin
          errors++;
          $display("FAIL %s pulse: new_ball=%b enable=%b one cycle later, required 0 1",
                   name, new_ball, enable_ball_gate);
        end
      end
    end
  endtask

  task automatic start_game(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    model_best = BEST_RST;
    checks++;
    if ({score, misses, last_ms, best_ms, new_ball, enable_ball_gate} !==
        {10'd0, 3'd0, 14'd0, 14'(BEST_RST), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s clear: score=%0d misses=%0d last=%0d best=%0d nb=%b en=%b, required 0 0 0 %0d 0 0",
               name, score, misses, last_ms, best_ms, new_ball, enable_ball_gate, BEST_RST);
    end
    step();
    checks++;
    if (new_ball !== 1'b1 || enable_ball_gate !== 1'b0) begin
      errors++;
      $display("FAIL %s spawn: new_ball=%b enable=%b, required 1 0", name, new_ball, enable_ball_gate);
    end
    step();
    checks++;
    if (new_ball !== 1'b0 || enable_ball_gate !== 1'b1) begin
      errors++;
      $display("FAIL %s active: new_ball=%b enable=%b, required 0 1", name, new_ball, enable_ball_gate);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mouse_left = 1'b1;
    mouse_x = 10'd100; mouse_y = 10'd100; ball_x = 10'd100; ball_y = 10'd100;
    step();
    step();
    checks++;
    if ({new_ball, enable_ball_gate, game_over, score, misses, last_ms, best_ms} !==
        {3'b000, 10'd0, 3'd0, 14'd0, 14'(BEST_RST)}) begin
      errors++;
      $display("FAIL reset: nb=%b en=%b go=%b score=%0d misses=%0d last=%0d best=%0d, required all 0, best %0d",
               new_ball, enable_ball_gate, game_over, score, misses, last_ms, best_ms, BEST_RST);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({new_ball, enable_ball_gate, game_over} !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold: nb/en/go=%b, required 000", {new_ball, enable_ball_gate, game_over});
    end
  endtask

  task automatic test_start();
    start_game("start");
    wait_active();
  endtask

  // Button has been held since reset with the cursor on the ball: no click may
  // register until it is released and pressed again.
  task automatic test_hit();
    to_edge(10);
    mouse_left = 1'b0;
    to_edge(19);
    checks++;
    if (score !== 10'd0 || enable_ball_gate !== 1'b1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL held_button: score=%0d en=%b go=%b, required 0 1 0", score, enable_ball_gate, game_over);
    end
    click(110, 110);
    push_expect(1'b0, 23, 1, 0, 5);
    note_hit(5);
    wait_outcome("hit");
  endtask

  task automatic test_miss_click();
    wait_active();
    to_edge(5);
    click(112, 112);
    to_edge(8);
    checks++;
    if (score !== 10'd1 || misses !== 3'd0 || enable_ball_gate !== 1'b1) begin
      errors++;
      $display("FAIL click_miss_resume: score=%0d misses=%0d en=%b, required 1 0 1",
               score, misses, enable_ball_gate);
    end
    push_expect(1'b0, 43, 1, 1, 5);
    wait_outcome("click_miss_timeout");
  endtask

  task automatic test_click_timeout_hit();
    wait_active();
    to_edge(40);
    click(100, 100);
    push_expect(1'b0, 44, 2, 1, 10);
    note_hit(10);
    wait_outcome("click_at_timeout_hit");
  endtask

  task automatic test_timeout_in_check();
    wait_active();
    to_edge(40);
    click(300, 300);
    push_expect(1'b0, 44, 2, 2, 10);
    wait_outcome("timeout_in_check");
  endtask

  task automatic test_game_over();
    wait_active();
    push_expect(1'b1, 42, 2, 3, 10);
    wait_outcome("final_timeout");
    ball_x = 10'd300; ball_y = 10'd300;
    click(300, 300);
    step();
    click(300, 300);
    step();
    step();
    step();
    checks++;
    if ({game_over, enable_ball_gate, new_ball} !== 3'b100 || score !== 10'd2 || misses !== 3'd3) begin
      errors++;
      $display("FAIL over_ignores_clicks: go/en/nb=%b score=%0d misses=%0d, required 100 2 3",
               {game_over, enable_ball_gate, new_ball}, score, misses);
    end
    start_game("restart");
  endtask

  task automatic test_three_timeouts();
    for (int i = 1; i <= 3; i++) begin
      wait_active();
      push_expect(i == 3, (i == 3) ? 42 : 43, 0, i, 0);
      wait_outcome($sformatf("timeout_%0d", i));
    end
    checks++;
    if (enable_ball_gate !== 1'b0) begin
      errors++;
      $display("FAIL over_gate: enable_ball_gate=%b, required 0", enable_ball_gate);
    end
  endtask

  task automatic test_reset_mid_game();
    ball_x = 10'd100; ball_y = 10'd100;
    start_game("restart2");
    wait_active();
    to_edge(19);
    click(110, 110);
    push_expect(1'b0, 23, 1, 0, 5);
    note_hit(5);
    wait_outcome("hit2");
    wait_active();
    to_edge(5);
    rst = 1'b1;
    step();
    checks++;
    if ({new_ball, enable_ball_gate, game_over, score, misses, last_ms, best_ms} !==
        {3'b000, 10'd0, 3'd0, 14'd0, 14'(BEST_RST)}) begin
      errors++;
      $display("FAIL reset_mid_game: nb=%b en=%b go=%b score=%0d misses=%0d last=%0d best=%0d, required all 0, best %0d",
               new_ball, enable_ball_gate, game_over, score, misses, last_ms, best_ms, BEST_RST);
    end
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({new_ball, enable_ball_gate, game_over} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: nb/en/go=%b, required 000", {new_ball, enable_ball_gate, game_over});
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_miss_click();
    test_click_timeout_hit();
    test_timeout_in_check();
    test_game_over();
    test_three_timeouts();
    test_reset_mid_game();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outcomes left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
